// File: rtl/chain_accum_if.sv
// rtl/chain_accum_if.sv - request/result bundle for the chain_accum accumulator
interface chain_accum_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] din;
    logic             out_valid;
    logic [WIDTH-1:0] acc;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, op, din,
        input  in_ready, out_valid, acc, cout, ovf
    );

    modport slave (
        input  in_valid, op, din,
        output in_ready, out_valid, acc, cout, ovf
    );
endinterface

// File: rtl/chain_accum.sv
// rtl/chain_accum.sv - two-stage registered accumulator on a split p/g ripple carry chain
module chain_accum #(
    parameter int               WIDTH = 16,
    parameter int               SPLIT = 8,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic       C,
    input  logic       R,
    chain_accum_if.slave bus
);
    localparam int HW = WIDTH - SPLIT;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;

    typedef enum logic {S_IDLE, S_HI} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  acc_q;
    logic              cout_q, ovf_q, out_valid_q;
    logic [SPLIT-1:0]  lo_sum_q, lo_sum_d;
    logic              lo_carry_q, lo_carry_d;
    logic [HW-1:0]     hi_b_q, hi_b_d;
    logic              arith_q, arith_d;

    logic              accept, finish;
    logic [SPLIT-1:0]  lo_b, lo_p, lo_g, lo_ripple;
    logic              lo_c;
    logic [HW-1:0]     hi_p, hi_g, hi_sum;
    logic              hi_c, c_msb;

    // FSM: IDLE accepts a request, HI finishes the upper segment
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        finish  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    state_d = S_HI;
                end
            end
            S_HI: begin
                finish  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Low segment: subtract is add of the inverted operand with carry-in 1
    always_comb begin
        lo_b      = (bus.op == OP_SUB) ? ~bus.din[SPLIT-1:0] : bus.din[SPLIT-1:0];
        lo_c      = (bus.op == OP_SUB);
        lo_p      = '0;
        lo_g      = '0;
        lo_ripple = '0;
        for (int i = 0; i < SPLIT; i++) begin
            lo_p[i]      = acc_q[i] ^ lo_b[i];
            lo_g[i]      = acc_q[i] & lo_b[i];
            lo_ripple[i] = lo_p[i] ^ lo_c;
            lo_c         = lo_p[i] ? lo_c : lo_g[i];
        end

        arith_d    = ~bus.op[1];
        lo_carry_d = lo_c;
        case (bus.op)
            OP_ADD:  begin lo_sum_d = lo_ripple;            hi_b_d = bus.din[WIDTH-1:SPLIT];  end
            OP_SUB:  begin lo_sum_d = lo_ripple;            hi_b_d = ~bus.din[WIDTH-1:SPLIT]; end
            OP_LOAD: begin lo_sum_d = bus.din[SPLIT-1:0];   hi_b_d = bus.din[WIDTH-1:SPLIT];  end
            default: begin lo_sum_d = '0;                   hi_b_d = '0;                      end
        endcase
    end

    // High segment continues the ripple from the registered low carry
    always_comb begin
        hi_c   = lo_carry_q;
        c_msb  = lo_carry_q;
        hi_p   = '0;
        hi_g   = '0;
        hi_sum = '0;
        for (int j = 0; j < HW; j++) begin
            hi_p[j]   = acc_q[SPLIT+j] ^ hi_b_q[j];
            hi_g[j]   = acc_q[SPLIT+j] & hi_b_q[j];
            hi_sum[j] = hi_p[j] ^ hi_c;
            if (j == HW - 1) begin
                c_msb = hi_c;
            end
            hi_c = hi_p[j] ? hi_c : hi_g[j];
        end
    end

    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            state_q     <= S_IDLE;
            acc_q       <= INIT;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            lo_sum_q    <= '0;
            lo_carry_q  <= 1'b0;
            hi_b_q      <= '0;
            arith_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= finish;
            if (accept) begin
                lo_sum_q   <= lo_sum_d;
                lo_carry_q <= lo_carry_d;
                hi_b_q     <= hi_b_d;
                arith_q    <= arith_d;
            end
            if (finish) begin
                if (arith_q) begin
                    acc_q  <= {hi_sum, lo_sum_q};
                    cout_q <= hi_c;
                    ovf_q  <= c_msb ^ hi_c;
                end else begin
                    acc_q  <= {hi_b_q, lo_sum_q};
                    cout_q <= 1'b0;
                    ovf_q  <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.acc       = acc_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_chain_accum.sv
// tb/tb_chain_accum.sv - randomized and directed checks of chain_accum against an arithmetic model
module tb_chain_accum;
    localparam int WIDTH = 16;

    logic C = 1'b0;
    logic R = 1'b0;
    always #5 C = ~C;

    chain_accum_if #(.WIDTH(WIDTH)) bus ();

    chain_accum #(.WIDTH(WIDTH), .SPLIT(8), .INIT(16'h0000)) dut (
        .C   (C),
        .R   (R),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] m_acc  = 16'h0000;
    logic        m_cout = 1'b0;
    logic        m_ovf  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Reference: plain integer arithmetic and signed-overflow rules
    task automatic model(input logic [1:0] op, input logic [15:0] d);
        logic [16:0] wide;
        case (op)
            2'b00: begin
                wide   = {1'b0, m_acc} + {1'b0, d};
                m_ovf  = (m_acc[15] == d[15]) && (wide[15] != m_acc[15]);
                m_cout = wide[16];
                m_acc  = wide[15:0];
            end
            2'b01: begin
                wide   = {1'b0, m_acc} + {1'b0, ~d} + 17'd1;
                m_ovf  = (m_acc[15] != d[15]) && (wide[15] != m_acc[15]);
                m_cout = wide[16];
                m_acc  = wide[15:0];
            end
            2'b10: begin m_acc = d;     m_cout = 1'b0; m_ovf = 1'b0; end
            default: begin m_acc = '0;  m_cout = 1'b0; m_ovf = 1'b0; end
        endcase
    endtask

    task automatic do_op(input logic [1:0] op, input logic [15:0] d);
        int waited = 0;
        @(negedge C);
        while (!bus.in_ready && waited < 10) begin
            waited++;
            @(negedge C);
        end
        check("ready_before_op", {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.din      = d;
        @(posedge C);
        #1;
        bus.in_valid = 1'b0;
        bus.din      = $urandom;
        bus.op       = 2'($urandom);
        model(op, d);
        check("valid_after_1", {31'd0, bus.out_valid}, 32'd0);
        check("busy_after_1", {31'd0, bus.in_ready}, 32'd0);
        @(posedge C);
        #1;
        check("valid_after_2", {31'd0, bus.out_valid}, 32'd1);
        check("acc", {16'd0, bus.acc}, {16'd0, m_acc});
        check("cout", {31'd0, bus.cout}, {31'd0, m_cout});
        check("ovf", {31'd0, bus.ovf}, {31'd0, m_ovf});
    endtask

    task automatic reset_model();
        m_acc  = 16'h0000;
        m_cout = 1'b0;
        m_ovf  = 1'b0;
    endtask

    task automatic check_idle_state(input string tag);
        check({tag, "_acc"}, {16'd0, bus.acc}, 32'h0);
        check({tag, "_cout"}, {31'd0, bus.cout}, 32'd0);
        check({tag, "_ovf"}, {31'd0, bus.ovf}, 32'd0);
        check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd0);
        check({tag, "_ready"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        int accepts;
        int pulses;
        int seen_valid;
        bus.in_valid = 1'b0;
        bus.op       = 2'b00;
        bus.din      = '0;

        repeat (3) @(posedge C);
        #1;
        check_idle_state("reset");
        @(negedge C);
        R = 1'b1;

        do_op(2'b00, 16'h00FF);
        do_op(2'b00, 16'h0001);
        do_op(2'b10, 16'h7FFF);
        do_op(2'b00, 16'h0001);
        do_op(2'b00, 16'h8000);
        do_op(2'b11, 16'hABCD);
        do_op(2'b01, 16'h0001);
        do_op(2'b01, 16'hFFFF);

        // Request held high: accepted every other cycle
        do_op(2'b11, 16'h0000);
        accepts = 0;
        pulses  = 0;
        @(negedge C);
        bus.in_valid = 1'b1;
        bus.op       = 2'b00;
        bus.din      = 16'h0001;
        for (int k = 0; k < 8; k++) begin
            check("hold_ready", {31'd0, bus.in_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            if (bus.in_ready) accepts++;
            @(posedge C);
            #1;
            if (bus.out_valid) pulses++;
            @(negedge C);
        end
        bus.in_valid = 1'b0;
        for (int k = 0; k < 4; k++) model(2'b00, 16'h0001);
        check("hold_accepts", accepts, 4);
        check("hold_pulses", pulses, 4);
        check("hold_acc", {16'd0, bus.acc}, 32'h0004);

        for (int k = 0; k < 150; k++) begin
            logic [1:0]  rop;
            logic [15:0] rd;
            rop = 2'($urandom_range(0, 9) < 4 ? 0 : ($urandom_range(0, 5) < 4 ? 1 : $urandom_range(2, 3)));
            case ($urandom_range(0, 4))
                0: rd = 16'hFFFF;
                1: rd = 16'h8000;
                2: rd = 16'h00FF;
                default: rd = 16'($urandom);
            endcase
            do_op(rop, rd);
        end

        // Reset while the upper segment is pending discards the operation
        do_op(2'b10, 16'h4321);
        @(negedge C);
        bus.in_valid = 1'b1;
        bus.op       = 2'b00;
        bus.din      = 16'h1234;
        @(posedge C);
        #1;
        bus.in_valid = 1'b0;
        R = 1'b0;
        #1;
        reset_model();
        check_idle_state("midreset");
        seen_valid = 0;
        repeat (2) begin
            @(posedge C);
            #1;
            if (bus.out_valid) seen_valid++;
        end
        @(negedge C);
        R = 1'b1;
        repeat (2) begin
            @(posedge C);
            #1;
            if (bus.out_valid) seen_valid++;
        end
        check("midreset_no_pulse", seen_valid, 0);
        do_op(2'b00, 16'h0005);
        check("after_reset_acc", {16'd0, bus.acc}, 32'h0005);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end
endmodule
